image_bank: RTL and testbench
=============================

# image_bank

Parametrised image buffer and replay engine for the convolution datapath. It accepts a packed pixel stream (`str_img_*`) and unpacks each stream word into one or more group words of `GROUP_NB` pixels. Each group word is written into a dual-port memory at a configured base address. On command it replays a configured address window onto the image bus (`image_*`) one or more times. This is the multi-pass successor of `image`: wider stream packing, wrapping address windows and repeat support for kernel reuse.

## Interface
- `CFG_DWIDTH`, 32, config data width (≥ 32)
- `CFG_AWIDTH`, 5, config address width
- `STR_IMG_WIDTH`, 64, stream word width; must equal `PACK_NB*GROUP_NB*IMG_WIDTH`, where `PACK_NB` (derived) ≥ 1
- `GROUP_NB`, 4, pixels per group word
- `IMG_WIDTH`, 16, bits per pixel
- `MEM_AWIDTH`, 8, memory address width (≤ 16); depth is 2^MEM_AWIDTH group words
- `CFG_IMG_WR`, 8, config address that arms a write window
- `CFG_IMG_RD`, 9, config address that launches a read pass
- `CFG_IMG_RPT`, 10, config address of the repeat register
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cfg_data`  in  CFG_DWIDTH  config payload
- `cfg_addr`  in  CFG_AWIDTH  config register select
- `cfg_valid`  in  1  config strobe, single cycle
- `str_img_bus`  in  STR_IMG_WIDTH  packed pixels; sub-word 0 is the LSBs
- `str_img_val`  in  1  stream valid
- `str_img_rdy`  out  1  stream ready
- `image_bus`  out  GROUP_NB*IMG_WIDTH  replayed group word
- `image_last`  out  1  marks the last word of each pass
- `image_val`  out  1  output valid
- `image_rdy`  in  1  output ready

## Operation
- Config fields for `CFG_IMG_WR` and `CFG_IMG_RD`: `[15:0]` start address (low MEM_AWIDTH bits used), `[31:16]` word count.
  - A count of 0 is ignored.
  - Counts larger than 2^MEM_AWIDTH are clamped to 2^MEM_AWIDTH.
- `CFG_IMG_RPT`: `[15:0]` repeat value R; each read command runs R+1 passes. Reset value is 0. The register is sampled when `CFG_IMG_RD` is accepted.
- Unknown `cfg_addr` values are ignored.
- Write FSM, states W_IDLE and W_RUN.
  - `CFG_IMG_WR` in W_IDLE loads the address and count, then goes to W_RUN. The same command in W_RUN is ignored.
  - In W_RUN a stream word is accepted on `str_img_val & str_img_rdy`.
  - Its PACK_NB sub-words are written on consecutive cycles, lowest sub-word first, one memory word per cycle.
  - The write address increments modulo 2^MEM_AWIDTH after each write; the count decrements.
  - `str_img_rdy` = W_RUN and (unpack register empty, or its last sub-word is being written this cycle, with the count not reaching 0). This gives a throughput of 1 stream word per PACK_NB cycles.
  - When the count reaches 0, any remaining sub-words are discarded and the FSM returns to W_IDLE.
- Read FSM, states R_IDLE and R_RUN.
  - `CFG_IMG_RD` in R_IDLE loads the start address, length and pass counter, then goes to R_RUN. The same command in R_RUN is ignored.
  - The FSM issues one read per cycle while a credit is available.
  - Addresses run start..start+len−1 modulo 2^MEM_AWIDTH, then restart at start for the next pass.
  - After the last read of the last pass it returns to R_IDLE. Words already in flight still drain.
- Output path: memory with 1-cycle read latency feeding a 2-entry output FIFO.
  - A read issues when `fifo_cnt + inflight − (image_val & image_rdy) < 2`.
  - `image_last` travels with its data word and is set for the final address of each pass.
- Write and read run concurrently on separate ports. A read and a write to the same address in the same cycle return the old data. There is no collision interlock.

## Timing
- Reset values: `str_img_rdy`=0, `image_val`=0, `image_last`=0, `image_bus`=0. Both FSMs go to IDLE, the FIFO is flushed and R=0. Memory contents are not reset.
- Reset is asynchronous: assertion mid-transfer clears outputs immediately. Release is synchronised to `clk`.
- Write: `str_img_rdy` rises the cycle after the accepted `CFG_IMG_WR`.
- Read: if `CFG_IMG_RD` is accepted in cycle T, `image_val` first rises in cycle T+3.
- With `image_rdy` held high, the output delivers 1 word per cycle with no bubbles between passes.
- `image_val` and data stay stable while `image_rdy`=0 (AXI-style hold).
- Words that are not popped are never lost or duplicated.

## Test plan
- Reset: hold `rst`=0 for 6 cycles -> all outputs 0 and `str_img_rdy`=0; after release, still idle with no `image_val`.
- Write then read (default params, PACK_NB=1):
  - Stimulus: WR start=0 count=4; stream 0x0004_0003_0002_0001 and the next 3 words; RD start=0 count=4.
  - Required response: the 4 words appear in order, `image_last` only on the 4th, and the first `image_val` comes 3 cycles after the RD strobe.
- Packing (STR_IMG_WIDTH=128): one stream word {B,A} with WR count=2 -> memory holds A at address 0 and B at address 1; `str_img_rdy` is low during the second sub-word write.
- Backpressure: toggle `image_rdy` every other cycle during an 8-word read -> output still has exactly 8 ordered words, stable while stalled.
- Wrap and repeat: RPT=2, then RD start=254 count=4 with MEM_AWIDTH=8 -> address sequence 254,255,0,1 three times, 12 words, `image_last` on words 4, 8 and 12.
- Boundaries:
  - A second RD mid-pass is ignored.
  - WR count=0 is ignored.
  - Asserting `rst`=0 mid-read drops `image_val` immediately, and a fresh RD afterwards replays correctly.

Source files
------------

// File: rtl/image_bank.sv
// image_bank: buffers a packed pixel stream into a dual-port group-word memory and
// replays configured address windows onto the image bus, with wrap and multi-pass repeat.
module image_bank #(
    parameter int CFG_DWIDTH    = 32,
    parameter int CFG_AWIDTH    = 5,
    parameter int STR_IMG_WIDTH = 64,
    parameter int GROUP_NB      = 4,
    parameter int IMG_WIDTH     = 16,
    parameter int MEM_AWIDTH    = 8,
    parameter int CFG_IMG_WR    = 8,
    parameter int CFG_IMG_RD    = 9,
    parameter int CFG_IMG_RPT   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [STR_IMG_WIDTH-1:0]      str_img_bus,
    input  logic                          str_img_val,
    output logic                          str_img_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    output logic                          image_last,
    output logic                          image_val,
    input  logic                          image_rdy
);

    localparam int GW      = GROUP_NB * IMG_WIDTH;
    localparam int PACK_NB = STR_IMG_WIDTH / GW;
    localparam int PW      = $clog2(PACK_NB + 1);
    localparam int CW      = MEM_AWIDTH + 1;
    localparam int DEPTH   = 1 << MEM_AWIDTH;

    typedef enum logic {W_IDLE, W_RUN} w_state_t;
    typedef enum logic {R_IDLE, R_RUN} r_state_t;

    // Word counts saturate at the memory depth so a window never laps itself.
    function automatic logic [CW-1:0] clamp_cnt(input logic [15:0] raw);
        logic [16:0] depth_v;
        logic [16:0] raw_v;
        depth_v = 17'd1 << MEM_AWIDTH;
        raw_v   = {1'b0, raw};
        if (raw_v > depth_v) begin
            clamp_cnt = depth_v[CW-1:0];
        end else begin
            clamp_cnt = raw_v[CW-1:0];
        end
    endfunction

    logic [1:0]            rst_sync_r;
    logic                  rst_n_s;
    logic                  cfg_wr_s, cfg_rd_s, cfg_rpt_s, cfg_zero_s;
    logic [MEM_AWIDTH-1:0] cfg_start_s;
    logic [CW-1:0]         cfg_cnt_s;
    logic                  cfg_unused_s;

    w_state_t              w_state_r, w_state_s;
    logic [MEM_AWIDTH-1:0] w_addr_r;
    logic [CW-1:0]         w_cnt_r;
    logic [STR_IMG_WIDTH-1:0] pk_data_r;
    logic [PW-1:0]         pk_left_r;
    logic                  wr_en_s, w_done_s, str_rdy_s, acc_s;

    r_state_t              r_state_r, r_state_s;
    logic [MEM_AWIDTH-1:0] r_start_r, r_addr_r;
    logic [CW-1:0]         r_len_r, r_left_r;
    logic [15:0]           r_pass_r, rpt_r;
    logic                  rd_issue_s, r_end_s, r_done_s, credit_s;
    logic [2:0]            occ_s;

    logic [GW-1:0]         mem_r [DEPTH];
    logic [GW-1:0]         rd_data_r;
    logic                  inflight_r, inflight_last_r;
    logic [GW-1:0]         h_data_r, t_data_r;
    logic                  h_val_r, t_val_r, h_last_r, t_last_r;
    logic                  pop_s;

    // Reset synchroniser: assertion is immediate, release follows two clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_r[1];

    assign cfg_wr_s     = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_IMG_WR));
    assign cfg_rd_s     = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_IMG_RD));
    assign cfg_rpt_s    = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_IMG_RPT));
    assign cfg_zero_s   = (cfg_data[31:16] == 16'd0);
    assign cfg_start_s  = cfg_data[MEM_AWIDTH-1:0];
    assign cfg_cnt_s    = clamp_cnt(cfg_data[31:16]);
    assign cfg_unused_s = ^cfg_data;

    // Write FSM next state and stream handshake.
    always_comb begin
        w_state_s = w_state_r;
        wr_en_s   = 1'b0;
        w_done_s  = 1'b0;
        str_rdy_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (cfg_wr_s && !cfg_zero_s) begin
                    w_state_s = W_RUN;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_RUN: begin
                wr_en_s   = (pk_left_r != PW'(0));
                w_done_s  = wr_en_s && (w_cnt_r == CW'(1));
                str_rdy_s = (pk_left_r == PW'(0)) || ((pk_left_r == PW'(1)) && !w_done_s);
                if (w_done_s) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RUN;
                end
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    assign str_img_rdy = str_rdy_s;
    assign acc_s       = str_img_val && str_rdy_s;

    // Write window counters and the unpack shift register.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            w_state_r <= W_IDLE;
            w_addr_r  <= '0;
            w_cnt_r   <= '0;
            pk_data_r <= '0;
            pk_left_r <= '0;
        end else begin
            w_state_r <= w_state_s;
            if ((w_state_r == W_IDLE) && cfg_wr_s && !cfg_zero_s) begin
                w_addr_r  <= cfg_start_s;
                w_cnt_r   <= cfg_cnt_s;
                pk_left_r <= '0;
            end else begin
                if (wr_en_s) begin
                    w_addr_r <= w_addr_r + MEM_AWIDTH'(1);
                    w_cnt_r  <= w_cnt_r - CW'(1);
                end
                if (acc_s) begin
                    pk_data_r <= str_img_bus;
                    pk_left_r <= PW'(PACK_NB);
                end else if (w_done_s) begin
                    pk_left_r <= '0;
                end else if (wr_en_s) begin
                    pk_data_r <= pk_data_r >> GW;
                    pk_left_r <= pk_left_r - PW'(1);
                end
            end
        end
    end

    // Memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[w_addr_r] <= pk_data_r[GW-1:0];
        end
    end

    // Memory read port: one-cycle latency, old data on a same-address write.
    always_ff @(posedge clk) begin
        if (rd_issue_s) begin
            rd_data_r <= mem_r[r_addr_r];
        end
    end

    assign pop_s    = h_val_r && image_rdy;
    assign occ_s    = 3'(h_val_r) + 3'(t_val_r) + 3'(inflight_r);
    assign credit_s = (occ_s - 3'(pop_s)) < 3'd2;

    // Read FSM next state and issue decision.
    always_comb begin
        r_state_s  = r_state_r;
        rd_issue_s = 1'b0;
        r_end_s    = 1'b0;
        r_done_s   = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (cfg_rd_s && !cfg_zero_s) begin
                    r_state_s = R_RUN;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_RUN: begin
                rd_issue_s = credit_s;
                r_end_s    = rd_issue_s && (r_left_r == CW'(1));
                r_done_s   = r_end_s && (r_pass_r == 16'd0);
                if (r_done_s) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_RUN;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read window, pass counter, repeat register and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            r_state_r       <= R_IDLE;
            r_start_r       <= '0;
            r_addr_r        <= '0;
            r_len_r         <= '0;
            r_left_r        <= '0;
            r_pass_r        <= 16'd0;
            rpt_r           <= 16'd0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            r_state_r       <= r_state_s;
            inflight_r      <= rd_issue_s;
            inflight_last_r <= r_end_s;
            if (cfg_rpt_s) begin
                rpt_r <= cfg_data[15:0];
            end
            if ((r_state_r == R_IDLE) && cfg_rd_s && !cfg_zero_s) begin
                r_start_r <= cfg_start_s;
                r_addr_r  <= cfg_start_s;
                r_len_r   <= cfg_cnt_s;
                r_left_r  <= cfg_cnt_s;
                r_pass_r  <= rpt_r;
            end else if (rd_issue_s) begin
                if (r_end_s) begin
                    r_addr_r <= r_start_r;
                    r_left_r <= r_len_r;
                    if (!r_done_s) begin
                        r_pass_r <= r_pass_r - 16'd1;
                    end
                end else begin
                    r_addr_r <= r_addr_r + MEM_AWIDTH'(1);
                    r_left_r <= r_left_r - CW'(1);
                end
            end
        end
    end

    // Two-entry output FIFO: head drives the bus directly, tail absorbs the word in flight.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            h_data_r <= '0;
            h_last_r <= 1'b0;
            h_val_r  <= 1'b0;
            t_data_r <= '0;
            t_last_r <= 1'b0;
            t_val_r  <= 1'b0;
        end else begin
            if (!h_val_r || pop_s) begin
                if (t_val_r) begin
                    h_data_r <= t_data_r;
                    h_last_r <= t_last_r;
                    h_val_r  <= 1'b1;
                    t_val_r  <= inflight_r;
                    if (inflight_r) begin
                        t_data_r <= rd_data_r;
                        t_last_r <= inflight_last_r;
                    end
                end else begin
                    h_val_r  <= inflight_r;
                    h_last_r <= inflight_r && inflight_last_r;
                    if (inflight_r) begin
                        h_data_r <= rd_data_r;
                    end
                    t_val_r <= 1'b0;
                end
            end else if (inflight_r) begin
                t_data_r <= rd_data_r;
                t_last_r <= inflight_last_r;
                t_val_r  <= 1'b1;
            end
        end
    end

    assign image_bus  = h_data_r;
    assign image_last = h_last_r;
    assign image_val  = h_val_r;

endmodule

// File: tb/tb_image_bank.sv
// Directed self-checking bench for image_bank: default instance plus a 2-way packing instance.
module tb_image_bank;

    localparam logic [4:0] A_WR  = 5'd8;
    localparam logic [4:0] A_RD  = 5'd9;
    localparam logic [4:0] A_RPT = 5'd10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  cfg_data = '0;
    logic [4:0]   cfg_addr = '0;
    logic         cfg_valid = 1'b0;
    logic [63:0]  str_img_bus = '0;
    logic         str_img_val = 1'b0;
    logic         str_img_rdy;
    logic [63:0]  image_bus;
    logic         image_last;
    logic         image_val;
    logic         image_rdy = 1'b1;

    logic [31:0]  p_cfg_data = '0;
    logic [4:0]   p_cfg_addr = '0;
    logic         p_cfg_valid = 1'b0;
    logic [127:0] p_str_bus = '0;
    logic         p_str_val = 1'b0;
    logic         p_str_rdy;
    logic [63:0]  p_img_bus;
    logic         p_img_last;
    logic         p_img_val;
    logic         p_img_rdy = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    logic [64:0] exp_q[$];
    int first_cyc, last_cyc, got_n;

    always #5 clk = ~clk;

    image_bank u_dut (
        .clk(clk), .rst(rst),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .str_img_bus(str_img_bus), .str_img_val(str_img_val), .str_img_rdy(str_img_rdy),
        .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
        .image_rdy(image_rdy)
    );

    image_bank #(.STR_IMG_WIDTH(128), .MEM_AWIDTH(4)) u_dut_pk (
        .clk(clk), .rst(rst),
        .cfg_data(p_cfg_data), .cfg_addr(p_cfg_addr), .cfg_valid(p_cfg_valid),
        .str_img_bus(p_str_bus), .str_img_val(p_str_val), .str_img_rdy(p_str_rdy),
        .image_bus(p_img_bus), .image_last(p_img_last), .image_val(p_img_val),
        .image_rdy(p_img_rdy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wd(input int k);
        return {16'(4 * k + 4), 16'(4 * k + 3), 16'(4 * k + 2), 16'(4 * k + 1)};
    endfunction

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
    endtask

    task automatic p_cfg_write(input logic [4:0] a, input logic [31:0] d);
        p_cfg_addr  = a;
        p_cfg_data  = d;
        p_cfg_valid = 1'b1;
        tick();
        p_cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] w);
        str_img_bus = w;
        str_img_val = 1'b1;
        for (int i = 0; i < 20 && !str_img_rdy; i++) tick();
        check("send_rdy", str_img_rdy, 1);
        tick();
        str_img_val = 1'b0;
    endtask

    task automatic push_exp(input logic last, input logic [63:0] d);
        exp_q.push_back({last, d});
    endtask

    // Pops n words; mode 1 toggles image_rdy; optionally injects one cfg strobe at inj_cyc.
    task automatic collect(input int n, input int mode, input int inj_cyc,
                           input logic [4:0] inj_a, input logic [31:0] inj_d);
        int cyc;
        logic held;
        logic [64:0] held_v;
        logic [64:0] e;
        got_n = 0; first_cyc = -1; last_cyc = -1; held = 1'b0; cyc = 1;
        while (got_n < n && cyc < 200) begin
            image_rdy = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
            if (cyc == inj_cyc) begin
                cfg_addr = inj_a; cfg_data = inj_d; cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            if (held) begin
                check("hold_data", {image_last, image_bus}, held_v);
                check("hold_val", image_val, 1);
            end
            held = 1'b0;
            if (image_val) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (image_rdy) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    check("word", {image_last, image_bus}, e);
                    got_n++;
                    last_cyc = cyc;
                end else begin
                    held = 1'b1;
                    held_v = {image_last, image_bus};
                end
            end
            tick();
            cyc++;
        end
        cfg_valid = 1'b0;
        image_rdy = 1'b1;
        check("word_count", got_n, n);
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, image_val, 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 6 cycles
        repeat (6) @(posedge clk);
        #1;
        check("rst_rdy", str_img_rdy, 0);
        check("rst_val", image_val, 0);
        check("rst_last", image_last, 0);
        check("rst_bus", image_bus, 0);
        check("rst_p_rdy", p_str_rdy, 0);
        rst = 1'b1;
        repeat (4) tick();
        check("idle_val", image_val, 0);
        check("idle_rdy", str_img_rdy, 0);

        // Write 4 words at address 0
        cfg_write(A_WR, {16'd4, 16'd0});
        check("wr_rdy_rise", str_img_rdy, 1);
        for (int k = 0; k < 4; k++) send(wd(k));
        check("wr_rdy_last", str_img_rdy, 0);
        tick();
        check("wr_done_rdy", str_img_rdy, 0);

        // Read them back
        for (int k = 0; k < 4; k++) push_exp(k == 3, wd(k));
        cfg_write(A_RD, {16'd4, 16'd0});
        collect(4, 0, 0, 5'd0, 32'd0);
        check("rd_latency", first_cyc, 3);
        idle_chk("rd_extra", 3);

        // 8-word read under backpressure with an ignored second RD mid-pass
        cfg_write(A_WR, {16'd8, 16'd16});
        for (int k = 10; k < 18; k++) send(wd(k));
        tick();
        for (int k = 10; k < 18; k++) push_exp(k == 17, wd(k));
        cfg_write(A_RD, {16'd8, 16'd16});
        collect(8, 1, 5, A_RD, {16'd4, 16'd0});
        idle_chk("bp_extra", 6);

        // A zero-count write must not arm the window
        cfg_write(A_WR, {16'd0, 16'd5});
        check("wr_zero", str_img_rdy, 0);
        tick();
        check("wr_zero2", str_img_rdy, 0);

        // Wrapping window 254..1 replayed three times
        cfg_write(A_WR, {16'd4, 16'd254});
        for (int k = 20; k < 24; k++) send(wd(k));
        tick();
        cfg_write(A_RPT, 32'd2);
        for (int p = 0; p < 3; p++)
            for (int k = 20; k < 24; k++) push_exp(k == 23, wd(k));
        cfg_write(A_RD, {16'd4, 16'd254});
        collect(12, 0, 0, 5'd0, 32'd0);
        check("rpt_first", first_cyc, 3);
        check("rpt_span", last_cyc, 14);
        idle_chk("rpt_extra", 4);

        // Asynchronous reset mid-read, then a fresh read (repeat register back to 0)
        cfg_write(A_RD, {16'd4, 16'd0});
        tick();
        tick();
        check("mid_val", image_val, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_val", image_val, 0);
        check("rst_async_bus", image_bus, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        check("post_rst_val", image_val, 0);
        push_exp(1'b0, wd(22));
        push_exp(1'b0, wd(23));
        push_exp(1'b0, wd(2));
        push_exp(1'b1, wd(3));
        cfg_write(A_RD, {16'd4, 16'd0});
        collect(4, 0, 0, 5'd0, 32'd0);
        check("post_rst_latency", first_cyc, 3);
        idle_chk("post_rst_extra", 4);

        // Packing instance: one 128-bit word becomes two group words
        p_cfg_write(A_WR, {16'd2, 16'd0});
        check("pk_rdy_rise", p_str_rdy, 1);
        p_str_bus = {64'hBBBB_0002_BBBB_0001, 64'hAAAA_0002_AAAA_0001};
        p_str_val = 1'b1;
        tick();
        p_str_val = 1'b0;
        check("pk_rdy_sub0", p_str_rdy, 0);
        tick();
        check("pk_rdy_sub1", p_str_rdy, 0);
        tick();
        p_cfg_write(A_RD, {16'd2, 16'd0});
        check("pk_val_t1", p_img_val, 0);
        tick();
        tick();
        check("pk_val_a", p_img_val, 1);
        check("pk_word_a", {p_img_last, p_img_bus}, {1'b0, 64'hAAAA_0002_AAAA_0001});
        tick();
        check("pk_word_b", {p_img_last, p_img_bus}, {1'b1, 64'hBBBB_0002_BBBB_0001});
        tick();
        check("pk_val_end", p_img_val, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
